// File: rtl/arm_n_cntr_mon.sv
// Divided-clock monitor: measures high/low phase lengths of div_in in clk cycles,
// reports the recovered modulus, period mismatches, stalls and lock.
module arm_n_cntr_mon #(
    parameter int CNT_W        = 32,
    parameter int LOCK_PERIODS = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] modulus_out,
    output logic             valid,
    output logic             mismatch,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int                GW     = 4;
    localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
    localparam logic [GW-1:0]     LP_VAL = GW'(LOCK_PERIODS);

    state_t           state;
    state_t           state_next;
    logic             div_q;
    logic             rise;
    logic             fall;
    logic             stalled;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] h_len;
    logic [CNT_W-1:0] h_len_next;
    logic [CNT_W-1:0] mod_next;
    logic [GW-1:0]    good;
    logic [GW-1:0]    good_next;
    logic             valid_next;
    logic             mismatch_next;
    logic             timeout_next;
    logic             locked_next;

    assign rise    = div_in & ~div_q;
    assign fall    = ~div_in & div_q;
    assign stalled = (cnt == TO_VAL);
    assign cnt_inc = (cnt < TO_VAL) ? (cnt + ONE) : cnt;

    // Next-state, phase measurement and period evaluation
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        h_len_next    = h_len;
        mod_next      = modulus_out;
        good_next     = good;
        valid_next    = 1'b0;
        mismatch_next = 1'b0;
        timeout_next  = 1'b0;
        case (state)
            IDLE: begin
                // A fall here is a leftover of a stalled or reset phase and is ignored.
                if (rise) begin
                    state_next = HIGH;
                    cnt_next   = ONE;
                end else begin
                    state_next = IDLE;
                end
            end
            HIGH: begin
                if (stalled) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                    good_next    = {GW{1'b0}};
                end else if (fall) begin
                    state_next = LOW;
                    h_len_next = cnt;
                    cnt_next   = ONE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            LOW: begin
                if (stalled) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                    good_next    = {GW{1'b0}};
                end else if (rise) begin
                    state_next = HIGH;
                    cnt_next   = ONE;
                    if (h_len == cnt) begin
                        valid_next = 1'b1;
                        mod_next   = h_len;
                        if (h_len == modulus_out) begin
                            good_next = (good == LP_VAL) ? good : (good + 4'd1);
                        end else begin
                            good_next = 4'd1;
                        end
                    end else begin
                        mismatch_next = 1'b1;
                        good_next     = {GW{1'b0}};
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Lock follows the registered good count, but drops together with an error pulse.
        if (mismatch_next || timeout_next) begin
            locked_next = 1'b0;
        end else begin
            locked_next = (good == LP_VAL);
        end
    end

    // State, measurement registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_q       <= 1'b0;
            cnt         <= {CNT_W{1'b0}};
            h_len       <= {CNT_W{1'b0}};
            modulus_out <= {CNT_W{1'b0}};
            good        <= {GW{1'b0}};
            valid       <= 1'b0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_next;
            div_q       <= div_in;
            cnt         <= cnt_next;
            h_len       <= h_len_next;
            modulus_out <= mod_next;
            good        <= good_next;
            valid       <= valid_next;
            mismatch    <= mismatch_next;
            timeout     <= timeout_next;
            locked      <= locked_next;
        end
    end

endmodule
